// File: rtl/iq_byte_serializer_if.sv
// Stream bundle for the I/Q byte serializer: two 8-bit sample inputs (no tready)
// and one framed AXI-Stream byte output.
interface iq_byte_serializer_if;
   logic [7:0] s_axis_i_tdata;
   logic       s_axis_i_tvalid;
   logic [7:0] s_axis_q_tdata;
   logic       s_axis_q_tvalid;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;

   // Upstream sources plus the downstream byte sink.
   modport master (
      output s_axis_i_tdata, s_axis_i_tvalid, s_axis_q_tdata, s_axis_q_tvalid, m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   // Serializer side.
   modport slave (
      input  s_axis_i_tdata, s_axis_i_tvalid, s_axis_q_tdata, s_axis_q_tvalid, m_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/iq_byte_serializer.sv
// Re-serialises paired I/Q samples into a framed byte stream (HDR0, HDR1, I, Q, I, Q ...)
// through a pair FIFO; pairs arriving while the FIFO is full are dropped and counted.
module iq_byte_serializer #(
   parameter int         DEPTH     = 16,
   parameter int         FRAME_LEN = 256,
   parameter logic [7:0] HDR0      = 8'hA5,
   parameter logic [7:0] HDR1      = 8'h5A
) (
   input  logic                clk,
   input  logic                rst,
   iq_byte_serializer_if.slave bus,
   output logic                overflow,
   output logic                misalign_err,
   output logic [15:0]         drop_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [PW-1:0] PAIR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PAIR_ONE  = PW'(1);
   localparam logic [PW-1:0] PAIR_LAST = PW'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR0   = 3'd1,
      ST_HDR1   = 3'd2,
      ST_SEND_I = 3'd3,
      ST_SEND_Q = 3'd4
   } state_t;

   logic [15:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   state_t        state_r;
   logic [PW-1:0] pair_cnt_r;
   logic [7:0]    q_hold_r;
   logic [7:0]    tdata_r;
   logic          tvalid_r;
   logic          tlast_r;

   logic          overflow_r;
   logic          misalign_r;
   logic [15:0]   drop_count_r;

   logic          pair_in_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          push_s;
   logic          pop_s;
   logic          xfer_s;
   logic [15:0]   rd_data_s;

   assign pair_in_s    = bus.s_axis_i_tvalid & bus.s_axis_q_tvalid;
   // Full/empty come from the registered count so a same-cycle pop never frees a slot early.
   assign fifo_full_s  = (count_r == CNT_FULL);
   assign fifo_empty_s = (count_r == CNT_ZERO);
   assign push_s       = pair_in_s & ~fifo_full_s;
   assign xfer_s       = tvalid_r & bus.m_axis_tready;
   assign rd_data_s    = mem_r[rd_ptr_r];

   assign bus.m_axis_tdata  = tdata_r;
   assign bus.m_axis_tvalid = tvalid_r;
   assign bus.m_axis_tlast  = tlast_r;
   assign overflow          = overflow_r;
   assign misalign_err      = misalign_r;
   assign drop_count        = drop_count_r;

   // Pop decision: exactly the FSM transitions that load a new I byte from the FIFO head.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_IDLE:   pop_s = ~fifo_empty_s & (pair_cnt_r != PAIR_ZERO);
         ST_HDR1:   pop_s = xfer_s & ~fifo_empty_s;
         ST_SEND_Q: pop_s = xfer_s & ~fifo_empty_s & (pair_cnt_r != PAIR_LAST);
         default:   pop_s = 1'b0;
      endcase
   end

   // Pair storage; contents need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {bus.s_axis_i_tdata, bus.s_axis_q_tdata};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky error flags and saturating drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r   <= 1'b0;
         misalign_r   <= 1'b0;
         drop_count_r <= 16'h0000;
      end else begin
         if (bus.s_axis_i_tvalid ^ bus.s_axis_q_tvalid) begin
            misalign_r <= 1'b1;
         end
         if (pair_in_s & fifo_full_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != 16'hFFFF) begin
               drop_count_r <= drop_count_r + 16'd1;
            end
         end
      end
   end

   // Framing FSM with registered stream outputs; a stalled byte keeps its data and tlast.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         pair_cnt_r <= PAIR_ZERO;
         q_hold_r   <= 8'h00;
         tdata_r    <= 8'h00;
         tvalid_r   <= 1'b0;
         tlast_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  tvalid_r <= 1'b1;
                  tlast_r  <= 1'b0;
                  if (pair_cnt_r == PAIR_ZERO) begin
                     state_r <= ST_HDR0;
                     tdata_r <= HDR0;
                  end else begin
                     state_r  <= ST_SEND_I;
                     tdata_r  <= rd_data_s[15:8];
                     q_hold_r <= rd_data_s[7:0];
                  end
               end
            end
            ST_HDR0: begin
               if (xfer_s) begin
                  state_r <= ST_HDR1;
                  tdata_r <= HDR1;
               end
            end
            ST_HDR1: begin
               if (xfer_s) begin
                  if (!fifo_empty_s) begin
                     state_r  <= ST_SEND_I;
                     tdata_r  <= rd_data_s[15:8];
                     q_hold_r <= rd_data_s[7:0];
                  end else begin
                     state_r  <= ST_IDLE;
                     tvalid_r <= 1'b0;
                     tdata_r  <= 8'h00;
                  end
               end
            end
            ST_SEND_I: begin
               if (xfer_s) begin
                  state_r <= ST_SEND_Q;
                  tdata_r <= q_hold_r;
                  tlast_r <= (pair_cnt_r == PAIR_LAST);
               end
            end
            ST_SEND_Q: begin
               if (xfer_s) begin
                  tlast_r <= 1'b0;
                  if (pair_cnt_r == PAIR_LAST) begin
                     pair_cnt_r <= PAIR_ZERO;
                     if (!fifo_empty_s) begin
                        state_r <= ST_HDR0;
                        tdata_r <= HDR0;
                     end else begin
                        state_r  <= ST_IDLE;
                        tvalid_r <= 1'b0;
                        tdata_r  <= 8'h00;
                     end
                  end else begin
                     pair_cnt_r <= pair_cnt_r + PAIR_ONE;
                     if (!fifo_empty_s) begin
                        state_r  <= ST_SEND_I;
                        tdata_r  <= rd_data_s[15:8];
                        q_hold_r <= rd_data_s[7:0];
                     end else begin
                        state_r  <= ST_IDLE;
                        tvalid_r <= 1'b0;
                        tdata_r  <= 8'h00;
                     end
                  end
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               tvalid_r <= 1'b0;
               tlast_r  <= 1'b0;
               tdata_r  <= 8'h00;
            end
         endcase
      end
   end

endmodule
